// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache fill arbiter and its address generator.
// Latency: n/a (types only).
// Backpressure: n/a.
package cache_mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} arb_state_t;
  typedef enum logic {REQ_I, REQ_D} req_id_t;

  // 16-byte blocks: 4 offset bits, 8 halfword indices.
  localparam int BLOCK_OFFSET_W = 4;
  localparam int WORD_IDX_W     = 3;

endpackage

// File: rtl/cache_mem_arbiter_block_addr_gen.sv
// Block read-address generator: latches the block base and steps through its 8 words.
// Latency: addr reflects the loaded base on the cycle after load; advances 1 word per cycle.
// Backpressure: none; advance is driven by the arbiter in every ISSUE cycle.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            capture miss_addr's block base and restart at word 0
//   miss_addr       byte address of the missing block (offset bits ignored)
//   advance         step to the next word
//   addr            current word read address
//   last_issue      current word is the final word of the block
module block_addr_gen
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last_issue
);

  logic [ADDR_W-BLOCK_OFFSET_W-1:0] base_hi;
  logic [WORD_IDX_W-1:0]            issue_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_hi   <= '0;
      issue_cnt <= '0;
    end else if (load) begin
      base_hi   <= miss_addr[ADDR_W-1:BLOCK_OFFSET_W];
      issue_cnt <= '0;
    end else if (advance) begin
      issue_cnt <= issue_cnt + 1'b1;
    end
  end

  // Offset is formed by concatenation, so it can never carry into the upper bits.
  assign addr       = {base_hi, issue_cnt, 1'b0};
  assign last_issue = (issue_cnt == '1);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I/D cache block misses onto one memory port and streams 8-word fills back.
// Latency: grant + first read 1 cycle after the IDLE sample; done pulse 1 cycle after the 8th return.
// Backpressure: none; losing requester simply holds its miss until the winner's fill completes.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_miss/i_miss_addr            I-cache block request
//   d_miss/d_miss_addr            D-cache block request
//   i_grant/d_grant               owner of memory (one-hot or zero)
//   fill_data/fill_word           returned word and its index in the block
//   i_data_valid/d_data_valid     fill_data qualifier per requester
//   i_fill_done/d_fill_done       one-cycle block-complete pulse
//   mem_en/mem_addr               memory read request
//   mem_data/mem_data_valid       memory read return
//
// Optional: define CACHE_ARB_ROUND_ROBIN_EN to break ties toward the requester not served last;
// otherwise the D-cache always wins a tie.
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_miss,
  input  logic [ADDR_W-1:0]     i_miss_addr,
  input  logic                  d_miss,
  input  logic [ADDR_W-1:0]     d_miss_addr,
  output logic                  i_grant,
  output logic                  d_grant,
  output logic [DATA_W-1:0]     fill_data,
  output logic [WORD_IDX_W-1:0] fill_word,
  output logic                  i_data_valid,
  output logic                  d_data_valid,
  output logic                  i_fill_done,
  output logic                  d_fill_done,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  mem_data_valid
);

  localparam logic [WORD_IDX_W:0] RET_FULL = (WORD_IDX_W+1)'(WORDS_PER_BLOCK);

  arb_state_t            state, state_nxt;
  req_id_t               owner, winner;
  logic [WORD_IDX_W:0]   ret_cnt;
  logic                  load, advance, last_issue, accept, ret_complete;
  logic [ADDR_W-1:0]     gen_addr;

  block_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .miss_addr  ((winner == REQ_D) ? d_miss_addr : i_miss_addr),
    .advance    (advance),
    .addr       (gen_addr),
    .last_issue (last_issue)
  );

  // Returns count only while a fill is active and not yet full; strays are dropped.
  assign accept       = (state != IDLE) && mem_data_valid && (ret_cnt != RET_FULL);
  // Block is complete once all words are in, counting one arriving this cycle.
  assign ret_complete = (ret_cnt == RET_FULL) || (accept && (ret_cnt == RET_FULL - 1'b1));

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  req_id_t last_owner;

  always_comb begin
    winner = d_miss ? REQ_D : REQ_I;
    if (d_miss && i_miss)
      winner = (last_owner == REQ_I) ? REQ_D : REQ_I;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_owner <= REQ_I;
    else if (load) last_owner <= winner;
  end
`else
  assign winner = d_miss ? REQ_D : REQ_I;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= REQ_I;
      ret_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        owner   <= winner;
        ret_cnt <= '0;
      end else if (accept) begin
        ret_cnt <= ret_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (d_miss || i_miss) begin
          load      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        advance = 1'b1;
        if (last_issue)
          state_nxt = ret_complete ? DONE : DRAIN;
      end
      DRAIN: begin
        if (ret_complete)
          state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    i_grant      = (state != IDLE) && (owner == REQ_I);
    d_grant      = (state != IDLE) && (owner == REQ_D);
    i_data_valid = accept && (owner == REQ_I);
    d_data_valid = accept && (owner == REQ_D);
    i_fill_done  = (state == DONE) && (owner == REQ_I);
    d_fill_done  = (state == DONE) && (owner == REQ_D);
    mem_en       = (state == ISSUE);
    mem_addr     = mem_en ? gen_addr : '0;
    fill_data    = accept ? mem_data : '0;
    fill_word    = accept ? ret_cnt[WORD_IDX_W-1:0] : '0;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a latency-configurable memory model.
// Expected outputs per cycle come from a fill schedule table built from the block-fill rules.
// Every cycle's outputs are compared against the table, plus literal spot checks.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;

  localparam int NC = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss = 1'b0, d_miss = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0;
  logic        i_grant, d_grant, i_data_valid, d_data_valid, i_fill_done, d_fill_done;
  logic [15:0] fill_data, mem_addr;
  logic [2:0]  fill_word;
  logic        mem_en;
  logic [15:0] mem_data = '0;
  logic        mem_data_valid = 1'b0;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .i_grant(i_grant), .d_grant(d_grant),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        ig, dg, idv, ddv, idone, ddone, men;
    logic [15:0] maddr;
    logic [2:0]  fw;
    logic [15:0] fd;
  } exp_t;

  exp_t        exp_tab [NC];
  logic        req_v   [NC];
  logic [15:0] req_a   [NC];
  int          mem_lat  = 4;
  int          spur_cyc = -1;
  int          vectors = 0;
  int          miscompares = 0;
  bit          tb_ready = 1'b0;
  exp_t        act;

  // Memory: a read seen in cycle c returns in cycle c+mem_lat with data = addr ^ 5A3C.
  always @(negedge clk) begin
    if (tb_ready && cyc < NC) begin
      req_v[cyc] = mem_en;
      req_a[cyc] = mem_addr;
    end
  end

  always @(posedge clk) begin
    #2;
    if (cyc == spur_cyc) begin
      mem_data_valid = 1'b1;
      mem_data       = 16'hBEEF;
    end else if (cyc >= mem_lat && cyc < NC && req_v[cyc-mem_lat]) begin
      mem_data_valid = 1'b1;
      mem_data       = req_a[cyc-mem_lat] ^ 16'h5A3C;
    end else begin
      mem_data_valid = 1'b0;
      mem_data       = 16'h0000;
    end
  end

  // Per-cycle comparison of every output against the schedule table.
  always @(negedge clk) begin
    if (tb_ready && cyc < NC) begin
      act = {i_grant, d_grant, i_data_valid, d_data_valid, i_fill_done, d_fill_done,
             mem_en, mem_addr, fill_word, fill_data};
      vectors++;
      if (act !== exp_tab[cyc]) begin
        miscompares++;
        $display("FAIL outputs cyc %0d: got %h want %h", cyc, act, exp_tab[cyc]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Expected outputs of one fill whose miss is sampled in cycle s.
  task automatic plan_fill(input int s, input bit is_d, input logic [15:0] base,
                           input int lat, output int d);
    int          r;
    logic [15:0] a;
    d = s + 9 + lat;
    for (int c = s + 1; c <= d; c++) begin
      exp_tab[c].dg = is_d;
      exp_tab[c].ig = !is_d;
    end
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(2 * k);
      exp_tab[s+1+k].men   = 1'b1;
      exp_tab[s+1+k].maddr = a;
      r = s + 1 + k + lat;
      if (is_d) exp_tab[r].ddv = 1'b1;
      else      exp_tab[r].idv = 1'b1;
      exp_tab[r].fw = 3'(k);
      exp_tab[r].fd = a ^ 16'h5A3C;
    end
    if (is_d) exp_tab[d].ddone = 1'b1;
    else      exp_tab[d].idone = 1'b1;
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < NC; i++) exp_tab[i] = '0;
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  int  d;
  bit  rr_second_i;

  initial begin
    for (int i = 0; i < NC; i++) begin
      exp_tab[i] = '0;
      req_v[i]   = 1'b0;
      req_a[i]   = '0;
    end
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    rr_second_i = 1'b1;
`else
    rr_second_i = 1'b0;
`endif
    tb_ready = 1'b1;

    go(2);
    rst = 1'b0;

    // D-only fill of 0x1234, latency 4; the address change mid-fill is ignored.
    go(5);
    d_miss = 1'b1; d_miss_addr = 16'h1234;
    plan_fill(5, 1'b1, 16'h1230, 4, d);
    go(6);
    d_miss = 1'b0; d_miss_addr = 16'hFFFF;
    @(negedge clk); chk("first_addr", mem_addr, 16'h1230);
    go(10); @(negedge clk); chk("first_ret_valid", {d_data_valid, fill_word}, {1'b1, 3'd0});
    go(13); @(negedge clk); chk("last_addr", mem_addr, 16'h123E);
    go(17); @(negedge clk); chk("last_word", fill_word, 3'd7);
    go(18); @(negedge clk); chk("done_cyc13", {i_fill_done, d_fill_done}, 2'b01);

    // Spurious return while idle, then a fill whose requester drops its miss early.
    go(19);
    spur_cyc = 20;
    go(20); @(negedge clk); chk("spurious_dropped", {d_data_valid, fill_data}, 17'h0);
    go(22);
    d_miss = 1'b1; d_miss_addr = 16'h0ABC;
    plan_fill(22, 1'b1, 16'h0AB0, 4, d);
    go(24);
    d_miss = 1'b0;
    go(27); @(negedge clk); chk("post_spur_word0", {d_data_valid, fill_word}, {1'b1, 3'd0});

    // Simultaneous misses: D first, one idle cycle, then I.
    go(37);
    i_miss = 1'b1; i_miss_addr = 16'h0040;
    d_miss = 1'b1; d_miss_addr = 16'h8000;
    plan_fill(37, 1'b1, 16'h8000, 4, d);
    plan_fill(51, 1'b0, 16'h0040, 4, d);
    go(38);
    d_miss = 1'b0;
    @(negedge clk); chk("tie_d_wins", {i_grant, d_grant}, 2'b01);
    go(51); @(negedge clk); chk("idle_gap", {i_grant, d_grant}, 2'b00);
    go(52);
    i_miss = 1'b0;
    @(negedge clk); chk("i_served", {i_grant, mem_addr}, {1'b1, 16'h0040});

    // Both held through two fills: second winner depends on tie-break mode.
    go(66);
    i_miss = 1'b1; i_miss_addr = 16'h1110;
    d_miss = 1'b1; d_miss_addr = 16'h2220;
    plan_fill(66, 1'b1, 16'h2220, 4, d);
    if (rr_second_i) plan_fill(80, 1'b0, 16'h1110, 4, d);
    else             plan_fill(80, 1'b1, 16'h2220, 4, d);
    go(81);
    i_miss = 1'b0; d_miss = 1'b0;
    @(negedge clk); chk("second_tie", {i_grant, d_grant}, rr_second_i ? 2'b10 : 2'b01);

    // Latency-1 memory: fill completes 10 cycles after the sample.
    go(95);
    mem_lat = 1;
    go(96);
    d_miss = 1'b1; d_miss_addr = 16'h3456;
    plan_fill(96, 1'b1, 16'h3450, 1, d);
    go(97);
    d_miss = 1'b0;
    go(98);  @(negedge clk); chk("lat1_overlap", {mem_en, d_data_valid, fill_word}, {2'b11, 3'd0});
    go(105); @(negedge clk); chk("lat1_not_early", d_fill_done, 1'b0);
    go(106); @(negedge clk); chk("lat1_done", d_fill_done, 1'b1);
    go(108);
    mem_lat = 4;

    // Reset mid-issue (4th read), then a clean restart at offset 0.
    go(110);
    d_miss = 1'b1; d_miss_addr = 16'h7776;
    plan_fill(110, 1'b1, 16'h7770, 4, d);
    clear_from(114);
    go(111);
    d_miss = 1'b0;
    go(114);
    #2 rst = 1'b1;
    @(negedge clk); chk("reset_async", {d_grant, mem_en, mem_addr}, 18'h0);
    go(116);
    rst = 1'b0;
    go(120);
    d_miss = 1'b1; d_miss_addr = 16'h7776;
    plan_fill(120, 1'b1, 16'h7770, 4, d);
    go(121);
    d_miss = 1'b0;
    @(negedge clk); chk("restart_offset0", mem_addr, 16'h7770);

    go(140);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
